// File: rtl/cache_subsystem_pkg.sv
// Shared constants and helpers for the direct-mapped write-through cache demonstrator.
// Holds the address field widths, the memory init pattern and the reset-preloaded line list.
package cache_subsystem_pkg;

    localparam int unsigned ENUM_W    = 14;
    localparam int unsigned BNUM_W    = 14;
    localparam int unsigned LA_W      = 4;
    localparam int unsigned CADDR_W   = BNUM_W + LA_W;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WSEL_W    = 2;

    localparam logic [31:0] INIT_BASE = 32'hA000_0000;

    localparam int unsigned PRELOAD_LINES [2] = '{0, 3};

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_t;

    function automatic logic [31:0] init_word(input logic [31:0] byte_addr);
        return INIT_BASE + byte_addr;
    endfunction

    function automatic logic is_preload(input int unsigned line);
        logic hit;
        hit = 1'b0;
        foreach (PRELOAD_LINES[p]) begin
            if (PRELOAD_LINES[p] == line) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/cache_addr_decode.sv
// Combinational split of the CPU byte address into region/block/offset fields
// plus the cache index, tag and word select derived from them.
module cache_addr_decode
    import cache_subsystem_pkg::*;
#(
    parameter int unsigned IDX_W = 2,
    parameter int unsigned TAG_W = 26
) (
    input  logic [31:0]        RAMAddr,
    output logic [13:0]        ENum,
    output logic [13:0]        BNum,
    output logic [3:0]         LA,
    output logic [17:0]        CacheAddr,
    output logic [IDX_W-1:0]   index,
    output logic [TAG_W-1:0]   tag,
    output logic [WSEL_W-1:0]  wsel
);

    always_comb begin
        ENum      = RAMAddr[31:18];
        BNum      = RAMAddr[17:4];
        LA        = RAMAddr[3:0];
        CacheAddr = RAMAddr[17:0];
        index     = RAMAddr[4 +: IDX_W];
        tag       = {RAMAddr[31:18], RAMAddr[17:4+IDX_W]};
        wsel      = RAMAddr[3:2];
    end

endmodule

// File: rtl/cache_subsystem.sv
// Direct-mapped, write-through, no-write-allocate cache fused with a behavioural main memory.
// Reads return one cycle later on hit or miss; MRd flags the miss cycle.
module cache_subsystem
    import cache_subsystem_pkg::*;
#(
    parameter int unsigned LINES     = 4,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] RAMAddr,
    input  logic        RD,
    input  logic        CMWr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic [31:0] MDataIn,
    output logic [31:0] MDataOut,
    output logic        MRd,
    output logic [31:0] WrAddrIn,
    output logic [17:0] CacheAddr,
    output logic [13:0] ENum,
    output logic [13:0] BNum,
    output logic [3:0]  LA
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned MW_W  = $clog2(MEM_WORDS);
    localparam int unsigned TAG_W = ENUM_W + BNUM_W - IDX_W;

    logic [31:0]       mem       [MEM_WORDS];
    logic              line_vld  [LINES];
    logic [TAG_W-1:0]  line_tag  [LINES];
    logic [31:0]       line_data [LINES][LINE_WORDS];

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [MW_W-1:0]   mem_word;
    logic              hit;
    op_t               op;

    cache_addr_decode #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_decode (
        .RAMAddr   (RAMAddr),
        .ENum      (ENum),
        .BNum      (BNum),
        .LA        (LA),
        .CacheAddr (CacheAddr),
        .index     (index),
        .tag       (tag),
        .wsel      (wsel)
    );

    always_comb begin
        mem_word = RAMAddr[MW_W+1:2];
        hit      = line_vld[index] && (line_tag[index] == tag);
        op       = OP_IDLE;
        if (CMWr)     op = OP_WRITE;
        else if (!RD) op = OP_READ;
    end

    // Reset restores the init pattern and preloads the listed lines with their tag-0 blocks.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            DataOut  <= '0;
            MDataIn  <= '0;
            MDataOut <= '0;
            MRd      <= 1'b0;
            WrAddrIn <= '0;
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem[i[MW_W-1:0]] <= init_word({i[29:0], 2'b00});
            end
            for (int unsigned l = 0; l < LINES; l++) begin
                line_vld[l[IDX_W-1:0]] <= is_preload(l);
                line_tag[l[IDX_W-1:0]] <= '0;
                for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                    line_data[l[IDX_W-1:0]][k[WSEL_W-1:0]] <=
                        is_preload(l) ? init_word(l * 16 + k * 4) : '0;
                end
            end
        end else begin
            case (op)
                OP_WRITE: begin
                    mem[mem_word] <= DataIn;
                    WrAddrIn      <= RAMAddr;
                    MDataIn       <= DataIn;
                    MRd           <= 1'b0;
                    if (hit) line_data[index][wsel] <= DataIn;
                end
                OP_READ: begin
                    if (hit) begin
                        DataOut <= line_data[index][wsel];
                        MRd     <= 1'b0;
                    end else begin
                        // Whole aligned block refills in the same edge as the miss.
                        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                            line_data[index][k[WSEL_W-1:0]] <=
                                mem[{RAMAddr[MW_W+1:4], k[WSEL_W-1:0]}];
                        end
                        line_tag[index] <= tag;
                        line_vld[index] <= 1'b1;
                        MDataOut        <= mem[mem_word];
                        DataOut         <= mem[mem_word];
                        MRd             <= 1'b1;
                    end
                end
                default: MRd <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_subsystem.sv
// Directed self-checking bench for cache_subsystem with hand-computed expectations.
module tb_cache_subsystem;

    logic        CLK;
    logic        CLR;
    logic [31:0] RAMAddr;
    logic        RD;
    logic        CMWr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic [31:0] MDataIn;
    logic [31:0] MDataOut;
    logic        MRd;
    logic [31:0] WrAddrIn;
    logic [17:0] CacheAddr;
    logic [13:0] ENum;
    logic [13:0] BNum;
    logic [3:0]  LA;

    int unsigned n_cmp;
    int unsigned n_bad;

    cache_subsystem #(
        .LINES     (4),
        .MEM_WORDS (256)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .RAMAddr   (RAMAddr),
        .RD        (RD),
        .CMWr      (CMWr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MDataIn   (MDataIn),
        .MDataOut  (MDataOut),
        .MRd       (MRd),
        .WrAddrIn  (WrAddrIn),
        .CacheAddr (CacheAddr),
        .ENum      (ENum),
        .BNum      (BNum),
        .LA        (LA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%08h expected=%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] din);
        RD      = rd;
        CMWr    = wr;
        RAMAddr = addr;
        DataIn  = din;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        CLR = 1'b0;
        drive(1'b1, 1'b0, 32'h1234_5678, 32'h0);
        #1;
        check("rst_dataout",  DataOut,  32'h0);
        check("rst_mrd",      {31'b0, MRd}, 32'h0);
        check("rst_mdatain",  MDataIn,  32'h0);
        check("rst_mdataout", MDataOut, 32'h0);
        check("rst_wraddr",   WrAddrIn, 32'h0);
        check("rst_enum",     {18'b0, ENum}, 32'h0000_048D);
        check("rst_bnum",     {18'b0, BNum}, 32'h0000_0567);
        check("rst_la",       {28'b0, LA},   32'h0000_0008);
        check("rst_caddr",    {14'b0, CacheAddr}, 32'h0000_5678);
        step();
        step();
        CLR = 1'b1;

        // Preloaded line 0 hit.
        drive(1'b0, 1'b0, 32'h0000_0000, 32'h0);
        #1;
        check("dec0_enum", {18'b0, ENum}, 32'h0);
        check("dec0_bnum", {18'b0, BNum}, 32'h0);
        check("dec0_la",   {28'b0, LA},   32'h0);
        step();
        check("hit0_data", DataOut, 32'hA000_0000);
        check("hit0_mrd",  {31'b0, MRd}, 32'h0);

        // Miss on line 1, then held read hits.
        drive(1'b0, 1'b0, 32'h0000_0014, 32'h0);
        #1;
        check("dec14_enum", {18'b0, ENum}, 32'h0);
        check("dec14_bnum", {18'b0, BNum}, 32'h1);
        check("dec14_la",   {28'b0, LA},   32'h4);
        step();
        check("miss14_mrd",   {31'b0, MRd}, 32'h1);
        check("miss14_mdo",   MDataOut, 32'hA000_0014);
        check("miss14_data",  DataOut,  32'hA000_0014);
        step();
        check("held14_mrd",   {31'b0, MRd}, 32'h0);
        check("held14_data",  DataOut,  32'hA000_0014);

        // Idle holds everything, clears MRd.
        drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        step();
        check("idle_mrd",  {31'b0, MRd}, 32'h0);
        check("idle_data", DataOut, 32'hA000_0014);

        // Write miss on line 2: memory updated, no allocate.
        drive(1'b1, 1'b1, 32'h0000_0028, 32'h8888_8888);
        step();
        check("wm28_wraddr", WrAddrIn, 32'h0000_0028);
        check("wm28_mdi",    MDataIn,  32'h8888_8888);
        check("wm28_data",   DataOut,  32'hA000_0014);
        drive(1'b0, 1'b0, 32'h0000_0028, 32'h0);
        step();
        check("rd28_mrd",  {31'b0, MRd}, 32'h1);
        check("rd28_data", DataOut, 32'h8888_8888);

        // Write hit on preloaded line 3.
        drive(1'b1, 1'b1, 32'h0000_003C, 32'h3333_3333);
        step();
        check("wh3c_mdi", MDataIn, 32'h3333_3333);
        drive(1'b0, 1'b0, 32'h0000_003C, 32'h0);
        step();
        check("rd3c_mrd",  {31'b0, MRd}, 32'h0);
        check("rd3c_data", DataOut, 32'h3333_3333);
        // Evict line 3 via an aliasing region, then confirm memory took the write.
        drive(1'b0, 1'b0, 32'h0004_0030, 32'h0);
        step();
        check("ev3_mrd",  {31'b0, MRd}, 32'h1);
        check("ev3_data", DataOut, 32'hA000_0030);
        drive(1'b0, 1'b0, 32'h0000_003C, 32'h0);
        step();
        check("mem3c_mrd",  {31'b0, MRd}, 32'h1);
        check("mem3c_data", DataOut, 32'h3333_3333);

        // Write wins over simultaneous read.
        drive(1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678);
        step();
        check("wr04_data",   DataOut,  32'h3333_3333);
        check("wr04_mrd",    {31'b0, MRd}, 32'h0);
        check("wr04_wraddr", WrAddrIn, 32'h0000_0004);
        drive(1'b0, 1'b0, 32'h0000_0004, 32'h0);
        step();
        check("rd04_mrd",  {31'b0, MRd}, 32'h0);
        check("rd04_data", DataOut, 32'h1234_5678);

        // Conflict on index 0 from region 1; memory word 0 aliases.
        drive(1'b0, 1'b0, 32'h0004_0000, 32'h0);
        #1;
        check("conf_enum", {18'b0, ENum}, 32'h1);
        step();
        check("conf_mrd",  {31'b0, MRd}, 32'h1);
        check("conf_data", DataOut, 32'hA000_0000);
        drive(1'b0, 1'b0, 32'h0000_0000, 32'h0);
        step();
        check("evict0_mrd",  {31'b0, MRd}, 32'h1);
        check("evict0_data", DataOut, 32'hA000_0000);

        // Asynchronous reset during an active read.
        drive(1'b0, 1'b0, 32'h0000_0004, 32'h0);
        #2;
        CLR = 1'b0;
        #1;
        check("arst_data",  DataOut,  32'h0);
        check("arst_mrd",   {31'b0, MRd}, 32'h0);
        check("arst_mdi",   MDataIn,  32'h0);
        check("arst_wraddr", WrAddrIn, 32'h0);
        #1;
        CLR = 1'b1;
        step();
        check("post_rst_mrd",  {31'b0, MRd}, 32'h0);
        check("post_rst_data", DataOut, 32'hA000_0004);
        drive(1'b0, 1'b0, 32'h0000_0028, 32'h0);
        step();
        check("post_rst28_mrd",  {31'b0, MRd}, 32'h1);
        check("post_rst28_data", DataOut, 32'hA000_0028);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
